led_line_driver: RTL and testbench

- Parametrised multi-channel one-wire LED strip encoder (WS2812-class), generalising the fixed 4-line LED_SIG0..3 output of the LedLines TOP.
- Accepts one pixel word per channel per handshake and serialises all NUM_CH lines in lockstep, MSB first.
- Appends a latch (low) period after each frame.
- Sits between the pattern generator and the LED output pins; the pattern generator drives START, which is derived from SW.

---
 rtl/led_line_if.sv | 34 +++
 rtl/led_line_driver.sv | 154 +++++++++++++++
 tb/tb_led_line_driver.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/led_line_if.sv
// led_line_if: frame control, pixel handshake and LED line bundle for led_line_driver.
// CH_EN exists only when LEDLINE_CH_MASK_EN is defined.
interface led_line_if #(
  parameter int NUM_CH = 4,
  parameter int BPP    = 24,
  parameter int NPIX_W = 10
);
`ifdef LEDLINE_CH_MASK_EN
  logic [NUM_CH-1:0]     CH_EN;
`endif
  logic                  START;
  logic [NPIX_W-1:0]     NUM_PIXELS;
  logic [NUM_CH*BPP-1:0] PIX_DATA;
  logic                  PIX_VALID;
  logic                  PIX_READY;
  logic [NUM_CH-1:0]     LED_SIG;
  logic                  BUSY;
  logic                  DONE;
  logic                  UNDERRUN;
  modport master (
`ifdef LEDLINE_CH_MASK_EN
    output CH_EN,
`endif
    output START, NUM_PIXELS, PIX_DATA, PIX_VALID,
    input  PIX_READY, LED_SIG, BUSY, DONE, UNDERRUN
  );
  modport slave (
`ifdef LEDLINE_CH_MASK_EN
    input  CH_EN,
`endif
    input  START, NUM_PIXELS, PIX_DATA, PIX_VALID,
    output PIX_READY, LED_SIG, BUSY, DONE, UNDERRUN
  );
endinterface

// File: rtl/led_line_driver.sv
// led_line_driver: NUM_CH-line WS2812-class encoder, one-word holding buffer, MSB-first lockstep shifting.
// Define LEDLINE_CH_MASK_EN to add CH_EN, a per-frame channel mask sampled on an accepted START.
module led_line_driver #(
  parameter int NUM_CH       = 4,
  parameter int BPP          = 24,
  parameter int T_BIT        = 63,
  parameter int T0H          = 20,
  parameter int T1H          = 40,
  parameter int RESET_CYCLES = 15000,
  parameter int NPIX_W       = 10
) (
  input  logic      CLK,
  input  logic      RST,
  led_line_if.slave bus
);
  localparam int BW = $clog2(T_BIT);
  localparam int IW = $clog2(BPP);
  localparam int LW = $clog2(RESET_CYCLES);
  localparam int DW = NUM_CH * BPP;
  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, LATCH} state_t;
  state_t state_q, state_d;
  logic [DW-1:0] buf_q, buf_d, sh_q, sh_d;
  logic full_q, full_d, busy_q, busy_d, done_q, done_d, ur_q, ur_d;
  logic [NPIX_W-1:0] fetch_q, fetch_d, left_q, left_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [IW-1:0] bidx_q, bidx_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic [NUM_CH-1:0] led_q, led_d, ch_on;
  logic take;
`ifdef LEDLINE_CH_MASK_EN
  logic [NUM_CH-1:0] mask_q, mask_d;
  assign ch_on = mask_q;
`else
  assign ch_on = '1;
`endif
  assign bus.PIX_READY = !full_q && (fetch_q != '0);
  assign take          = bus.PIX_VALID && bus.PIX_READY;
  assign bus.LED_SIG   = led_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.UNDERRUN  = ur_q;
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    full_d  = full_q;
    fetch_d = fetch_q;
    left_d  = left_q;
    sh_d    = sh_q;
    bcnt_d  = bcnt_q;
    bidx_d  = bidx_q;
    lcnt_d  = lcnt_q;
    led_d   = '0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ur_d    = ur_q;
`ifdef LEDLINE_CH_MASK_EN
    mask_d  = mask_q;
`endif
    if (take) begin
      buf_d   = bus.PIX_DATA;
      full_d  = 1'b1;
      fetch_d = fetch_q - NPIX_W'(1);
    end
    case (state_q)
      IDLE: if (bus.START && !done_q) begin
        busy_d  = 1'b1;
        ur_d    = 1'b0;
        lcnt_d  = '0;
        fetch_d = bus.NUM_PIXELS;
        left_d  = bus.NUM_PIXELS;
`ifdef LEDLINE_CH_MASK_EN
        mask_d  = bus.CH_EN;
`endif
        state_d = (bus.NUM_PIXELS != '0) ? FETCH : LATCH;
      end
      FETCH: if (full_q) begin
        sh_d    = buf_q;
        full_d  = 1'b0;
        bcnt_d  = '0;
        bidx_d  = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        for (int k = 0; k < NUM_CH; k++)
          led_d[k] = ch_on[k] && (bcnt_q < (sh_q[k*BPP+BPP-1] ? BW'(T1H) : BW'(T0H)));
        bcnt_d = (bcnt_q == BW'(T_BIT - 1)) ? '0 : bcnt_q + BW'(1);
        if (bcnt_q == BW'(T_BIT - 1)) begin
          for (int k = 0; k < NUM_CH; k++)
            sh_d[k*BPP +: BPP] = {sh_q[k*BPP +: BPP-1], 1'b0};
          bidx_d = (bidx_q == IW'(BPP - 1)) ? '0 : bidx_q + IW'(1);
          if (bidx_q == IW'(BPP - 1)) begin
            left_d = left_q - NPIX_W'(1);
            // Reload straight from the buffer so consecutive pixels abut with no idle cycle.
            if (left_q == NPIX_W'(1)) begin
              lcnt_d  = '0;
              state_d = LATCH;
            end else if (full_q) begin
              sh_d   = buf_q;
              full_d = 1'b0;
            end else begin
              ur_d    = 1'b1;
              state_d = FETCH;
            end
          end
        end
      end
      LATCH: begin
        lcnt_d = lcnt_q + LW'(1);
        if (lcnt_q == LW'(RESET_CYCLES - 1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= IDLE;
      buf_q   <= '0;
      sh_q    <= '0;
      full_q  <= 1'b0;
      fetch_q <= '0;
      left_q  <= '0;
      bcnt_q  <= '0;
      bidx_q  <= '0;
      lcnt_q  <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ur_q    <= 1'b0;
`ifdef LEDLINE_CH_MASK_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      sh_q    <= sh_d;
      full_q  <= full_d;
      fetch_q <= fetch_d;
      left_q  <= left_d;
      bcnt_q  <= bcnt_d;
      bidx_q  <= bidx_d;
      lcnt_q  <= lcnt_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ur_q    <= ur_d;
`ifdef LEDLINE_CH_MASK_EN
      mask_q  <= mask_d;
`endif
    end
endmodule

// File: tb/tb_led_line_driver.sv
// tb_led_line_driver: directed frames for led_line_driver; expected pulses and DONE events
// are queued by the stimulus and popped by a line monitor as the DUT produces them.
`timescale 1ns/1ps
module tb_led_line_driver;
  localparam int NC = 4;
  localparam int BPP = 24;
  localparam int W = NC * BPP;
  typedef struct {int w; int p;} pulse_t;
  typedef struct {logic ur; int kind; int lat;} done_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #10 clk = ~clk;
  led_line_if #(.NUM_CH(NC), .BPP(BPP), .NPIX_W(10)) bus();
  led_line_driver dut (.CLK(clk), .RST(rst), .bus(bus));
  pulse_t pq[NC][$];
  done_t dq[$];
  pulse_t pe;
  done_t de;
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, hs = 0, last_start = 0, last_rise = 0;
  int rise_at[NC] = '{default: -1};
  int per[NC];
  logic [NC-1:0] prev = '0;
  logic [NC-1:0] exp_mask = '1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev = '0;
      for (int k = 0; k < NC; k++) rise_at[k] = -1;
    end else begin
      if (bus.PIX_VALID && bus.PIX_READY) hs++;
      if (bus.START && !bus.BUSY && !bus.DONE) last_start = cyc;
      for (int k = 0; k < NC; k++) begin
        if (bus.LED_SIG[k] && !prev[k]) begin
          per[k] = (rise_at[k] < 0) ? -1 : cyc - rise_at[k];
          rise_at[k] = cyc;
          last_rise = cyc;
        end else if (!bus.LED_SIG[k] && prev[k]) begin
          if (pq[k].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected pulse ch%0d: got width %0d expected no pulse", k, cyc - rise_at[k]);
          end else begin
            pe = pq[k].pop_front();
            chk($sformatf("ch%0d width", k), 64'(cyc - rise_at[k]), 64'(pe.w));
            if (pe.p > 0) chk($sformatf("ch%0d period", k), 64'(per[k]), 64'(pe.p));
          end
        end
      end
      prev = bus.LED_SIG;
      if (bus.DONE) begin
        if (dq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected done: got 1 expected 0");
        end else begin
          de = dq.pop_front();
          chk("done underrun", 64'(bus.UNDERRUN), 64'(de.ur));
          if (de.kind == 1) chk("done after start", 64'(cyc - last_start), 64'(de.lat));
          if (de.kind == 2) chk("done after last bit", 64'(cyc - last_rise), 64'(de.lat));
        end
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push_pixel(input logic [W-1:0] d, input int p0);
    pulse_t e;
    for (int k = 0; k < NC; k++)
      if (exp_mask[k])
        for (int b = BPP - 1; b >= 0; b--) begin
          e.w = d[k*BPP+b] ? 40 : 20;
          e.p = (b == BPP - 1) ? p0 : 63;
          pq[k].push_back(e);
        end
  endtask
  task automatic push_done(input logic ur, input int kind, input int lat);
    done_t e;
    e.ur = ur;
    e.kind = kind;
    e.lat = lat;
    dq.push_back(e);
  endtask
  task automatic start_frame(input int n);
    bus.NUM_PIXELS = 10'(n);
    bus.START = 1'b1;
    tick(1);
    bus.START = 1'b0;
  endtask
  task automatic send(input logic [W-1:0] d);
    bit ok;
    ok = 1'b0;
    bus.PIX_DATA = d;
    bus.PIX_VALID = 1'b1;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      ok = bus.PIX_READY;
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send handshake: got ready 0 expected 1");
    end
    @(posedge clk);
    #1;
  endtask
  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = bus.DONE;
    end
    chk("done seen", 64'(seen), 64'd1);
    @(posedge clk);
    #1;
  endtask
  task automatic check_empty();
    for (int k = 0; k < NC; k++) chk($sformatf("ch%0d leftover pulses", k), 64'(pq[k].size()), 64'd0);
    chk("leftover done", 64'(dq.size()), 64'd0);
  endtask
  initial begin
    #1980000;
    $display("FAIL watchdog: got timeout expected summary");
    $fatal(1, "watchdog");
  end
  initial begin
    int hs0;
    logic [W-1:0] wa, wb, wc;
    bus.START = 1'b0;
    bus.NUM_PIXELS = '0;
    bus.PIX_DATA = '0;
    bus.PIX_VALID = 1'b0;
`ifdef LEDLINE_CH_MASK_EN
    bus.CH_EN = '1;
`endif
    #1 rst = 1'b1;
    tick(3);
    @(negedge clk);
    chk("reset led", 64'(bus.LED_SIG), 64'd0);
    chk("reset busy", 64'(bus.BUSY), 64'd0);
    chk("reset done", 64'(bus.DONE), 64'd0);
    chk("reset ready", 64'(bus.PIX_READY), 64'd0);
    chk("reset underrun", 64'(bus.UNDERRUN), 64'd0);
    tick(1);
    rst = 1'b0;
    tick(2);
    // Empty frame: latch only; a START during LATCH must not restart it.
    push_done(1'b0, 1, 15001);
    start_frame(0);
    tick(5000);
    chk("busy mid-latch", 64'(bus.BUSY), 64'd1);
    start_frame(0);
    wait_done(12000);
    chk("busy after done", 64'(bus.BUSY), 64'd0);
    check_empty();
    // Starve, resume, then reset mid-SHIFT with the next word still owed.
    wa = {24'h00FFFF, 24'h0F0F0F, 24'h5A5A5A, 24'hC00003};
    wb = {24'h800000, 24'h800000, 24'h800000, 24'h800000};
    push_pixel(wa, 0);
    start_frame(3);
    send(wa);
    bus.PIX_VALID = 1'b0;
    tick(1600);
    chk("underrun after starve", 64'(bus.UNDERRUN), 64'd1);
    chk("line low while starved", 64'(bus.LED_SIG), 64'd0);
    send(wb);
    bus.PIX_VALID = 1'b0;
    tick(4);
    chk("ready for third word", 64'(bus.PIX_READY), 64'd1);
    chk("line high before reset", 64'(bus.LED_SIG), 64'hF);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async reset led", 64'(bus.LED_SIG), 64'd0);
    chk("async reset busy", 64'(bus.BUSY), 64'd0);
    chk("async reset ready", 64'(bus.PIX_READY), 64'd0);
    chk("async reset underrun", 64'(bus.UNDERRUN), 64'd0);
    check_empty();
    tick(3);
    rst = 1'b0;
    tick(2);
    // Single pixel: ch0 = 8 ones then 16 zeros, other lines all zeros.
    wa = {24'h000000, 24'h000000, 24'h000000, 24'hFF0000};
    hs0 = hs;
    push_pixel(wa, 0);
    push_done(1'b0, 2, 15062);
    start_frame(1);
    send(wa);
    bus.PIX_VALID = 1'b0;
    wait_done(17000);
    chk("one pixel handshakes", 64'(hs - hs0), 64'd1);
    chk("one pixel underrun", 64'(bus.UNDERRUN), 64'd0);
    check_empty();
    // Three pixels with VALID held: contiguous bits, exactly three transfers.
    wa = {24'hFFFFFF, 24'h800001, 24'h123456, 24'hA5F00F};
    wb = {24'h000000, 24'h7FFFFE, 24'hFEDCBA, 24'h000001};
    wc = {24'hAAAAAA, 24'h555555, 24'hF0F0F0, 24'h8000FF};
    hs0 = hs;
    push_pixel(wa, 0);
    push_pixel(wb, 63);
    push_pixel(wc, 63);
    push_done(1'b0, 2, 15062);
    start_frame(3);
    send(wa);
    send(wb);
    send(wc);
    tick(20);
    bus.PIX_VALID = 1'b0;
    wait_done(21000);
    chk("three pixel handshakes", 64'(hs - hs0), 64'd3);
    check_empty();
    // Second word arrives 200 cycles late: gap grows from 63 to 263.
    wa = {24'h0000FF, 24'h00FF00, 24'hFF0000, 24'hF00000};
    wb = {24'hFFFF00, 24'h0F0F0F, 24'h000001, 24'hC0FFEE};
    hs0 = hs;
    push_pixel(wa, 0);
    push_pixel(wb, 263);
    push_done(1'b1, 2, 15062);
    start_frame(2);
    send(wa);
    bus.PIX_VALID = 1'b0;
    tick(1711);
    chk("gap line low", 64'(bus.LED_SIG), 64'd0);
    send(wb);
    bus.PIX_VALID = 1'b0;
    wait_done(17000);
    chk("underrun frame handshakes", 64'(hs - hs0), 64'd2);
    check_empty();
`ifdef LEDLINE_CH_MASK_EN
    // Mask ch1 and ch3; ch0/ch2 unchanged.
    bus.CH_EN = 4'b0101;
    exp_mask = 4'b0101;
    wa = {24'hFF00FF, 24'hC3C3C3, 24'hFFFFFF, 24'hFF0000};
    push_pixel(wa, 0);
    push_done(1'b0, 2, 15062);
    start_frame(1);
    bus.CH_EN = '1;
    send(wa);
    bus.PIX_VALID = 1'b0;
    wait_done(17000);
    check_empty();
    exp_mask = '1;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
